// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// FSM encoding, owner encoding and default abort timeout.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_C = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 16;

    function automatic arb_state_e busy_state_for(input logic owner);
        return (owner == OWN_DBG) ? ST_BUSY_D : ST_BUSY_C;
    endfunction

endpackage

// File: rtl/dmem_arb_rr2.sv
// rtl/dmem_arb_rr2.sv - two-way round-robin picker
// Grant bit 0 is the core, bit 1 the debug requester; a tie goes to whoever was not served last.
module dmem_arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = (last_owner_i == OWN_DBG) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter in front of a single data-memory port
// Optional BUSY abort timer enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,

    output logic        rsp_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e  state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        c_rvalid_q, c_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic [1:0]  gnt;
    logic        busy;
    logic        owner;
    logic        timeout;
    logic        rsp_fire;
    logic [31:0] rsp_data;

    assign busy  = (state_q != ST_IDLE);
    assign owner = (state_q == ST_BUSY_D) ? OWN_DBG : OWN_CORE;

    // Grants are only offered from IDLE and are forced low while reset is held.
    dmem_arb_rr2 u_rr2 (
        .en_i        ((state_q == ST_IDLE) && reset),
        .req_i       ({d_req, c_req}),
        .last_owner_i(last_owner_q),
        .gnt_o       (gnt)
    );

    assign c_gnt = gnt[0];
    assign d_gnt = gnt[1];

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter sits at zero in IDLE, so every BUSY entry starts a fresh count.
    assign cnt_d   = busy ? (cnt_q + 1'b1) : '0;
    assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_d   = busy && !m_ready && timeout;
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign rsp_fire = busy && (m_ready || timeout);
    assign rsp_data = (m_ready && !we_q) ? m_rdata : 32'h0;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        c_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        c_rdata_d    = c_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt[0]) begin
                    addr_d       = c_addr;
                    wdata_d      = c_wdata;
                    we_d         = c_we;
                    last_owner_d = OWN_CORE;
                    state_d      = busy_state_for(OWN_CORE);
                end else if (gnt[1]) begin
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    we_d         = d_we;
                    last_owner_d = OWN_DBG;
                    state_d      = busy_state_for(OWN_DBG);
                end
            end
            ST_BUSY_C, ST_BUSY_D: begin
                if (rsp_fire) begin
                    if (owner == OWN_DBG) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = rsp_data;
                    end else begin
                        c_rvalid_d = 1'b1;
                        c_rdata_d  = rsp_data;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_DBG;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            we_q         <= 1'b0;
            c_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            c_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            c_rvalid_q   <= c_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            c_rdata_q    <= c_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_req    = busy;
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding memory access, one pending response.
    bit          mdl_active;
    bit          mdl_owner;
    logic [31:0] mdl_addr, mdl_wdata;
    bit          mdl_we;
    int          mdl_cnt;
    bit          mdl_last_dbg;
    bit          mdl_rv_c, mdl_rv_d, mdl_err;
    logic [31:0] mdl_rdata_c, mdl_rdata_d;

    task automatic mdl_respond(input logic [31:0] data, input bit err);
        mdl_active = 0;
        mdl_err    = err;
        if (mdl_owner) begin
            mdl_rv_d = 1; mdl_rdata_d = data;
        end else begin
            mdl_rv_c = 1; mdl_rdata_c = data;
        end
    endtask

    always @(negedge clk) begin
        bit eg_c, eg_d;
        if (!reset) begin
            mdl_active = 0; mdl_last_dbg = 1; mdl_cnt = 0;
            mdl_rv_c = 0; mdl_rv_d = 0; mdl_err = 0;
            mdl_rdata_c = 0; mdl_rdata_d = 0;
            chk("rst_c_gnt", c_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_m_req", m_req, 0);
            chk("rst_c_rvalid", c_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_c_rdata", c_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end else begin
            eg_c = !mdl_active && c_req && (!d_req || mdl_last_dbg);
            eg_d = !mdl_active && d_req && !eg_c;
            chk("mdl_c_gnt", c_gnt, eg_c);
            chk("mdl_d_gnt", d_gnt, eg_d);
            chk("mdl_m_req", m_req, mdl_active);
            if (mdl_active) begin
                chk("mdl_m_addr", m_addr, mdl_addr);
                chk("mdl_m_wdata", m_wdata, mdl_wdata);
                chk("mdl_m_we", m_we, mdl_we);
            end
            chk("mdl_c_rvalid", c_rvalid, mdl_rv_c);
            chk("mdl_d_rvalid", d_rvalid, mdl_rv_d);
            if (mdl_rv_c || mdl_rv_d) chk("mdl_rsp_err", rsp_err, mdl_err);
            chk("mdl_c_rdata", c_rdata, mdl_rdata_c);
            chk("mdl_d_rdata", d_rdata, mdl_rdata_d);

            mdl_rv_c = 0; mdl_rv_d = 0; mdl_err = 0;
            if (mdl_active) begin
                mdl_cnt++;
                if (m_ready) begin
                    mdl_respond(mdl_we ? 32'h0 : m_rdata, 0);
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (mdl_cnt == TO) begin
                    mdl_respond(32'h0, 1);
                end
`endif
            end else if (eg_c || eg_d) begin
                mdl_active   = 1;
                mdl_owner    = eg_d;
                mdl_last_dbg = eg_d;
                mdl_cnt      = 0;
                mdl_addr     = eg_d ? d_addr  : c_addr;
                mdl_wdata    = eg_d ? d_wdata : c_wdata;
                mdl_we       = eg_d ? d_we    : c_we;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit order [4];
        int ng;
        bit got;

        reset = 0; m_ready = 0; m_rdata = 0;
        c_req = 1; c_we = 1; c_addr = 132; c_wdata = 32'hABCDE02E;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_gnt_gated", c_gnt, 0);

        // Core write, memory ready after two BUSY cycles
        step(); reset = 1;
        @(negedge clk); chk("wr_c_gnt", c_gnt, 1);
        step(); c_req = 0; c_addr = 32'hFFFF_FFFF; c_wdata = 0;
        @(negedge clk);
        chk("wr_m_addr1", m_addr, 132);
        chk("wr_m_wdata1", m_wdata, 32'hABCDE02E);
        chk("wr_m_we1", m_we, 1);
        step(); m_ready = 1; m_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("wr_m_addr2", m_addr, 132);
        chk("wr_m_wdata2", m_wdata, 32'hABCDE02E);
        step(); m_ready = 0;
        @(negedge clk);
        chk("wr_c_rvalid", c_rvalid, 1);
        chk("wr_c_rdata", c_rdata, 0);
        chk("wr_m_req_done", m_req, 0);
        step();
        @(negedge clk); chk("wr_c_rvalid_off", c_rvalid, 0);

        // Both requesting from reset: grants alternate starting with core
        step(); reset = 0;
        step(); reset = 1;
        c_req = 1; c_we = 0; c_addr = 8;
        d_req = 1; d_we = 0; d_addr = 16;
        m_ready = 1; m_rdata = 32'h1000;
        ng = 0;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            @(negedge clk);
            if (c_gnt) begin order[ng] = 0; ng++; end
            else if (d_gnt) begin order[ng] = 1; ng++; end
            step();
            m_rdata = 32'h1001 + i;
        end
        c_req = 0; d_req = 0;
        chk("alt_grant_count", ng, 4);
        chk("alt_grant0_core", order[0], 0);
        chk("alt_grant1_dbg", order[1], 1);
        chk("alt_grant2_core", order[2], 0);
        chk("alt_grant3_dbg", order[3], 1);
        step(); m_ready = 0;
        step();

        // Debug read returns registered memory data, core untouched
        d_req = 1; d_we = 0; d_addr = 32'h40;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            got = d_gnt;
            if (!got) step();
        end
        chk("rd_d_gnt", got, 1);
        step(); d_req = 0; m_ready = 1; m_rdata = 32'h12345678;
        @(negedge clk);
        chk("rd_m_addr", m_addr, 32'h40);
        chk("rd_m_we", m_we, 0);
        step(); m_ready = 0; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_d_rvalid", d_rvalid, 1);
        chk("rd_d_rdata", d_rdata, 32'h12345678);
        chk("rd_c_rvalid", c_rvalid, 0);
        step();
        @(negedge clk);
        chk("rd_d_rvalid_off", d_rvalid, 0);
        chk("rd_d_rdata_hold", d_rdata, 32'h12345678);
        step();

        // Memory never ready
        c_req = 1; c_we = 0; c_addr = 32'h200;
        @(negedge clk); chk("to_c_gnt", c_gnt, 1);
        step(); c_req = 0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk); chk($sformatf("to_m_req_%0d", i), m_req, 1);
            step();
        end
        @(negedge clk);
`ifdef DMEM_ARB_TIMEOUT_EN
        chk("to_c_rvalid", c_rvalid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_m_req_drop", m_req, 0);
        chk("to_c_rdata", c_rdata, 0);
`else
        chk("to_m_req_held", m_req, 1);
        chk("to_c_rvalid_none", c_rvalid, 0);
        step(); m_ready = 1; m_rdata = 32'h55AA;
        step(); m_ready = 0;
        @(negedge clk);
        chk("to_late_c_rvalid", c_rvalid, 1);
        chk("to_late_c_rdata", c_rdata, 32'h55AA);
        chk("to_late_rsp_err", rsp_err, 0);
`endif
        step();
        @(negedge clk); chk("to_c_rvalid_off", c_rvalid, 0);

        // Asynchronous reset in the middle of a core transaction
        step(); c_req = 1; c_we = 1; c_addr = 4; c_wdata = 77;
        @(negedge clk); chk("ar_c_gnt", c_gnt, 1);
        step(); c_req = 0;
        @(negedge clk); chk("ar_m_req_busy", m_req, 1);
        @(posedge clk); #3 reset = 0;
        #1;
        chk("ar_m_req_now", m_req, 0);
        chk("ar_c_rvalid_now", c_rvalid, 0);
        m_ready = 1;
        step(); reset = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_no_c_rvalid", c_rvalid, 0);
            chk("ar_idle_m_req", m_req, 0);
            step();
        end
        d_req = 1; d_we = 0; d_addr = 32'h80;
        @(negedge clk); chk("ar_idle_d_gnt", d_gnt, 1);
        step(); d_req = 0;
        step(); m_ready = 0;
        step();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max BUSY cycles before abort (used only with DMEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 SHALL have ports: c_req/c_we  input  1 each  core request, write-enable.
REQ-005 SHALL have ports: c_addr/c_wdata  input  32 each  core byte address, write data.
REQ-006 SHALL have ports: c_gnt/c_rvalid  output  1 each; c_rdata  output  32  core grant, response, read data.
REQ-007 SHALL have ports: d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, same widths and directions as core set  debug/DMA requester.
REQ-008 SHALL have ports: m_req/m_we  output  1 each; m_addr/m_wdata  output  32 each  data-memory side.
REQ-009 SHALL have ports: m_ready  input  1; m_rdata  input  32  memory completion, read data.
REQ-010 SHALL have port: rsp_err  output  1  error flag, qualified by c_rvalid or d_rvalid.

Function
REQ-011 SHALL implement FSM IDLE, BUSY_C, BUSY_D.
- Reset state: IDLE.
REQ-012 In IDLE with any request:
- *_gnt SHALL be asserted combinationally for exactly one requester.
- addr/wdata/we SHALL be latched.
- FSM SHALL move to BUSY_C or BUSY_D next edge.
REQ-013 Each requester SHALL hold req and payload stable until gnt; gnt SHALL never be asserted outside IDLE.
REQ-014 Simultaneous c_req and d_req SHALL be granted to the requester not served last (last_owner bit); only one requesting SHALL be granted regardless.
REQ-015 In BUSY_*:
- m_req SHALL be 1.
- m_addr/m_wdata/m_we SHALL be driven from latched values, constant until m_ready.
REQ-016 On an edge with m_ready=1 in BUSY_*:
- owner's rvalid SHALL be 1 for exactly the next cycle; rdata = registered m_rdata for reads, 0 for writes.
- FSM SHALL return to IDLE.
REQ-017 Non-owner rvalid SHALL stay 0; rdata SHALL hold its last value when rvalid=0.
REQ-018 Minimum turnaround SHALL be 3 cycles from req to rvalid (gnt cycle 0, m_req cycle 1, rvalid cycle 2 if m_ready in cycle 1).
- Back-to-back: new gnt possible in the rvalid cycle.
REQ-019 m_ready while in IDLE SHALL be ignored.

Reset
REQ-020 Asserting reset low SHALL immediately and asynchronously force:
- IDLE; last_owner = debug (core wins first tie).
- m_req, gnt, rvalid, rsp_err = 0; latched payload and rdata = 0.
REQ-021 Reset mid-transaction SHALL abandon it with no rvalid issued after release.

Configuration
REQ-022 Macro DMEM_ARB_TIMEOUT_EN defined:
- Counter SHALL count BUSY cycles.
- On reaching TIMEOUT_CYCLES without m_ready: m_req SHALL drop; owner rvalid SHALL pulse with rsp_err=1, rdata=0; FSM SHALL return to IDLE; counter SHALL clear on every BUSY entry.
REQ-023 Macro undefined: no counter; rsp_err SHALL be tied 0; BUSY SHALL wait indefinitely.

Structure
REQ-024 Package dmem_arb_pkg SHALL hold:
- FSM state enum.
- Owner encoding constants (OWN_CORE=0, OWN_DBG=1).
- Default TIMEOUT_CYCLES.
REQ-025 Sub-module dmem_arb_rr2 SHALL hold the 2-way round-robin picker (reqs, last_owner -> one-hot grant); rest SHALL be flat in dmem_arbiter.

Verification
REQ-026 Core write addr 132 data 32'hABCDE02E, m_ready after 2 BUSY cycles -> m_addr=132, m_wdata=32'hABCDE02E, m_we=1 stable; c_rvalid 1 cycle, c_rdata=0.
REQ-027 Both request from reset -> core granted first, debug next; repeat -> grants alternate C,D,C,D.
REQ-028 Debug read addr 0x40, m_rdata=32'h12345678 with m_ready -> d_rvalid next cycle, d_rdata=32'h12345678, c_rvalid=0.
REQ-029 reset low during BUSY_C -> m_req=0 at once; after release no c_rvalid, state IDLE.
REQ-030 With DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_ready held 0 -> after 16 BUSY cycles c_rvalid=1, rsp_err=1, m_req=0; without macro m_req stays 1.
